// File: rtl/icache_responder_pkg.sv
// Shared constants for the instruction-cache responder: FSM encoding and block geometry.
package icache_responder_pkg;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    localparam int BLOCK_WORDS = 8;
    localparam int WORD_BYTES  = 2;
    localparam int OFF_W       = 3;
    // One extra bit so the counters can express "all BLOCK_WORDS done".
    localparam int CNT_W       = OFF_W + 1;
endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage for a direct-mapped cache: asynchronous read, synchronous write,
// valids cleared asynchronously on reset.
module icache_line_array
    import icache_responder_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_off,
    output logic [15:0]      o_rd_word,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic             o_rd_valid,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_word_we,
    input  logic [OFF_W-1:0] i_wr_off,
    input  logic [15:0]      i_wr_word,
    input  logic             i_tag_we,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_inv
);
    logic [15:0]      r_data [LINES][BLOCK_WORDS];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (i_word_we) r_data[i_wr_idx][i_wr_off] <= i_wr_word;
        if (i_tag_we)  r_tag[i_wr_idx] <= i_wr_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= '0;
        else if (i_inv)
            r_valid[i_wr_idx] <= 1'b0;
        else if (i_tag_we)
            r_valid[i_wr_idx] <= 1'b1;
    end

    assign o_rd_word  = r_data[i_rd_idx][i_rd_off];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache for the fetch stage: zero-latency hits, stalling
// 8-word block fills from a pipelined backing memory on a miss.
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int LINES       = 8,
    parameter int BLOCK_WORDS = icache_responder_pkg::BLOCK_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_addr,
    input  logic        if_rd_en,
    output logic [15:0] if_data,
    output logic        if_stall,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [15:0] mem_data,
    input  logic        mem_valid
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 16 - 4 - IDX_W;
    localparam logic [CNT_W-1:0] BW_CNT = CNT_W'(BLOCK_WORDS);

    logic [0:0]       r_state;
    logic [15:0]      r_base;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_iss;
    logic [CNT_W-1:0] r_rcv;

    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [15:0]      w_word;
    logic [TAG_W-1:0] w_rd_tag;
    logic             w_rd_valid;
    logic             w_idle, w_hit, w_miss, w_issue, w_recv, w_last;

    assign w_off  = if_addr[3:1];
    assign w_idx  = if_addr[4 +: IDX_W];
    assign w_tag  = if_addr[15 -: TAG_W];
    assign w_idle = (r_state == ST_IDLE);

    assign w_hit   = w_idle && if_rd_en && w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss  = w_idle && if_rd_en && !(w_rd_valid && (w_rd_tag == w_tag));
    assign w_issue = !w_idle && (r_iss < BW_CNT);
    assign w_recv  = !w_idle && mem_valid;
    assign w_last  = w_recv && (r_rcv == BW_CNT - 1'b1);

    assign if_stall  = !w_idle || (if_rd_en && !w_hit);
    assign if_data   = w_hit ? w_word : 16'h0000;
    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? (r_base + 16'({r_iss[OFF_W-1:0], 1'b0})) : 16'h0000;

    // The miss cycle invalidates the looked-up line; during FILL writes target the latched line.
    icache_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .i_rd_off   (w_off),
        .o_rd_word  (w_word),
        .o_rd_tag   (w_rd_tag),
        .o_rd_valid (w_rd_valid),
        .i_wr_idx   (w_idle ? w_idx : r_idx),
        .i_word_we  (w_recv),
        .i_wr_off   (r_rcv[OFF_W-1:0]),
        .i_wr_word  (mem_data),
        .i_tag_we   (w_last),
        .i_wr_tag   (r_base[15 -: TAG_W]),
        .i_inv      (w_miss)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_idx   <= '0;
            r_iss   <= '0;
            r_rcv   <= '0;
        end else if (w_idle) begin
            if (w_miss) begin
                r_state <= ST_FILL;
                r_base  <= {if_addr[15:4], 4'h0};
                r_idx   <= w_idx;
                r_iss   <= '0;
                r_rcv   <= '0;
            end
        end else begin
            if (w_issue) r_iss <= r_iss + 1'b1;
            if (w_recv)  r_rcv <= r_rcv + 1'b1;
            if (w_last) begin
                r_state <= ST_IDLE;
                r_iss   <= '0;
                r_rcv   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: a backing-memory model, a line-residency model
// compared every cycle, and literal expectations for the documented scenarios.
module tb_icache_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] if_addr = 16'h0000;
    logic        if_rd_en = 1'b0;
    logic [15:0] if_data, mem_addr;
    logic        if_stall, mem_rd_en;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_valid = 1'b0;

    always #5 clk = ~clk;

    icache_responder #(.LINES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_addr   (if_addr),
        .if_rd_en  (if_rd_en),
        .if_data   (if_data),
        .if_stall  (if_stall),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_data  (mem_data),
        .mem_valid (mem_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Backing memory contents: every word is derived from its own address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + {1'b0, a[15:1]};
    endfunction

    // ---------------- backing memory: 4-cycle latency, optional gaps between returns
    typedef struct { logic [15:0] addr; int due; } req_t;
    req_t        rq[$];
    logic [15:0] req_log[$];
    int          req_cyc[$];
    int          mv_cnt = 0;
    bit          gap_mode = 0;
    int          gap_left = 0;
    int          gap_k = 0;
    int          gaps[8] = '{0, 3, 6, 1, 0, 5, 2, 4};

    initial forever begin
        req_t t;
        @(negedge clk);
        if (mem_rd_en === 1'b1) begin
            t.addr = mem_addr;
            t.due  = cyc + 4;
            rq.push_back(t);
            req_log.push_back(mem_addr);
            req_cyc.push_back(cyc);
        end
        @(posedge clk);
        cyc++;
        #1;
        mem_valid = 1'b0;
        mem_data  = 16'h0000;
        if (gap_left > 0)
            gap_left--;
        else if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_valid = 1'b1;
            mem_data  = mem_word(rq[0].addr);
            void'(rq.pop_front());
            mv_cnt++;
            if (gap_mode) begin
                gap_left = gaps[gap_k % 8];
                gap_k++;
            end
        end
    end

    // ---------------- residency model: which block each line holds, and the fill in progress
    bit          m_valid[8];
    int          m_tag[8];
    bit          m_fill = 0;
    int          m_idx = 0;
    int          m_ftag = 0;
    int          m_rcv = 0;
    logic [15:0] m_q[$];

    function automatic bit m_hit(input logic [15:0] a);
        int li;
        li = int'(a >> 4) % 8;
        return !m_fill && m_valid[li] && (m_tag[li] == int'(a >> 7));
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 0;
            m_fill = 0;
            m_rcv  = 0;
            m_q.delete();
        end else if (m_fill) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            if (mem_valid) begin
                m_rcv++;
                if (m_rcv == 8) begin
                    m_valid[m_idx] = 1;
                    m_tag[m_idx]   = m_ftag;
                    m_fill         = 0;
                end
            end
        end else if (if_rd_en && !m_hit(if_addr)) begin
            m_fill = 1;
            m_idx  = int'(if_addr >> 4) % 8;
            m_ftag = int'(if_addr >> 7);
            m_valid[m_idx] = 0;
            m_rcv  = 0;
            m_q.delete();
            for (int i = 0; i < 8; i++) m_q.push_back({if_addr[15:4], 4'h0} + 16'(2 * i));
        end
    end

    initial forever begin
        logic        e_stall, e_rd;
        logic [15:0] e_data, e_addr;
        @(negedge clk);
        e_stall = m_fill || (if_rd_en && !m_hit(if_addr));
        e_data  = (!m_fill && if_rd_en && m_hit(if_addr)) ? mem_word(if_addr) : 16'h0000;
        e_rd    = m_fill && (m_q.size() > 0);
        e_addr  = e_rd ? m_q[0] : 16'h0000;
        chk("cyc_if_stall", 16'(if_stall), 16'(e_stall));
        chk("cyc_if_data", if_data, e_data);
        chk("cyc_mem_rd_en", 16'(mem_rd_en), 16'(e_rd));
        chk("cyc_mem_addr", mem_addr, e_addr);
    end

    // ---------------- directed stimulus
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (if_stall && n < 300) begin
            step();
            n++;
        end
        chk(nm, 16'(if_stall), 16'h0000);
    endtask

    task automatic sweep(input string nm, input logic [15:0] base);
        for (int i = 0; i < 8; i++) begin
            if_addr = base + 16'(2 * i);
            #1;
            chk({nm, "_stall"}, 16'(if_stall), 16'h0000);
            chk({nm, "_data"}, if_data, 16'hA000 + (base >> 1) + 16'(i));
            step();
        end
    endtask

    initial begin
        int b, n0, mv0;
        rst = 1'b1;
        step(2);
        chk("rst_stall", 16'(if_stall), 16'h0000);
        chk("rst_data", if_data, 16'h0000);
        chk("rst_rd_en", 16'(mem_rd_en), 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        if_rd_en = 1'b1;
        #1;
        chk("rst_lookup_stall", 16'(if_stall), 16'h0001);
        rst = 1'b0;

        // first fill of block 0x0000
        b = req_log.size();
        #1;
        chk("miss0_stall", 16'(if_stall), 16'h0001);
        wait_ready("fill0_done");
        chk("fill0_data", if_data, 16'hA000);
        chk("fill0_nreq", 16'(req_log.size() - b), 16'd8);
        for (int i = 0; i < 8 && b + i < req_log.size(); i++) begin
            chk("fill0_req_addr", req_log[b + i], 16'(2 * i));
            chk("fill0_req_cyc", 16'(req_cyc[b + i] - req_cyc[b]), 16'(i));
        end

        n0 = req_log.size();
        sweep("hit0", 16'h0000);
        chk("hit0_no_req", 16'(req_log.size() - n0), 16'd0);

        // conflict on line 0
        if_addr = 16'h0080;
        #1;
        chk("conf_miss", 16'(if_stall), 16'h0001);
        wait_ready("conf_fill");
        chk("conf_data", if_data, 16'hA040);
        if_addr = 16'h0000;
        #1;
        chk("conf_remiss", 16'(if_stall), 16'h0001);
        wait_ready("conf_refill");
        chk("conf_redata", if_data, 16'hA000);

        // address moves away during a fill; fill completes for the latched block
        b = req_log.size();
        if_addr = 16'h0010;
        #1;
        chk("move_miss", 16'(if_stall), 16'h0001);
        step();
        if_addr = 16'h0100;
        wait_ready("move_fill");
        chk("move_nreq", 16'(req_log.size() - b), 16'd16);
        for (int i = 0; i < 16 && b + i < req_log.size(); i++)
            chk("move_req_addr", req_log[b + i],
                (i < 8) ? 16'(16'h0010 + 2 * i) : 16'(16'h0100 + 2 * (i - 8)));
        chk("move_data", if_data, 16'hA080);
        if_addr = 16'h0012;
        #1;
        chk("move_old_hit", if_data, 16'hA009);
        step();

        // reset in the middle of a fill
        if_addr = 16'h0200;
        mv0 = mv_cnt;
        for (int n = 0; n < 100 && mv_cnt < mv0 + 4; n++) step();
        step();
        rst = 1'b1;
        if_rd_en = 1'b0;
        #1;
        chk("midrst_rd_en", 16'(mem_rd_en), 16'h0000);
        chk("midrst_stall", 16'(if_stall), 16'h0000);
        step();
        rst = 1'b0;
        step(12);
        if_rd_en = 1'b1;
        #1;
        chk("midrst_remiss", 16'(if_stall), 16'h0001);
        wait_ready("midrst_fill");
        sweep("midrst_hit", 16'h0200);

        // irregular return gaps
        gap_mode = 1;
        if_addr = 16'h0030;
        #1;
        chk("gap_miss", 16'(if_stall), 16'h0001);
        wait_ready("gap_fill");
        gap_mode = 0;
        sweep("gap_hit", 16'h0030);

        if_rd_en = 1'b0;
        #1;
        chk("idle_stall", 16'(if_stall), 16'h0000);
        chk("idle_data", if_data, 16'h0000);
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
